// File: rtl/if_fetch_stage.sv
// MIPS-style instruction fetch: pre-IF computes nextpc and issues the SRAM read,
// IF holds the fetched pc/instruction and applies delayed-branch redirects.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_allowin,
  input  logic [33:0] br_bus,
  output logic        fs_to_ds_valid,
  output logic [63:0] fs_to_ds_bus,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_wen,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata
);

  typedef struct packed {
    logic        stall;
    logic        taken;
    logic [31:0] target;
  } br_bus_t;

  br_bus_t     w_br;
  logic        w_to_fs_valid, w_fs_ready_go, w_fs_allowin, w_issue, w_br_live;
  logic [31:0] w_seq_pc, w_nextpc, w_fs_inst;

  logic        r_fs_valid, r_br_pend_valid, r_slot_owed, r_inst_buf_valid, r_issued;
  logic [31:0] r_fs_pc, r_br_pend_target, r_inst_buf;

  assign w_br          = br_bus_t'(br_bus);
  assign w_to_fs_valid = !reset && !w_br.stall;
  assign w_fs_ready_go = 1'b1;
  assign w_fs_allowin  = !r_fs_valid || (w_fs_ready_go && ds_allowin);
  assign w_issue       = w_to_fs_valid && w_fs_allowin;
  assign w_seq_pc      = r_fs_pc + 32'd4;
  // A branch counts only when not stalled and no earlier redirect is outstanding.
  assign w_br_live     = w_br.taken && !w_br.stall && !r_br_pend_valid;

  always_comb begin
    w_nextpc = w_seq_pc;
    if (r_slot_owed)                  w_nextpc = w_seq_pc;
    else if (r_br_pend_valid)         w_nextpc = r_br_pend_target;
    else if (w_br_live && r_fs_valid) w_nextpc = w_br.target;
  end

  assign w_fs_inst       = r_inst_buf_valid ? r_inst_buf : inst_sram_rdata;
  assign fs_to_ds_valid  = r_fs_valid && w_fs_ready_go;
  assign fs_to_ds_bus    = {w_fs_inst, r_fs_pc};
  assign inst_sram_en    = w_issue;
  assign inst_sram_wen   = 4'h0;
  assign inst_sram_addr  = w_nextpc;
  assign inst_sram_wdata = 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fs_valid       <= 1'b0;
      r_fs_pc          <= RESET_PC - 32'd4;
      r_br_pend_valid  <= 1'b0;
      r_br_pend_target <= 32'h0;
      r_slot_owed      <= 1'b0;
      r_inst_buf_valid <= 1'b0;
      r_inst_buf       <= 32'h0;
      r_issued         <= 1'b0;
    end else begin
      r_issued <= w_issue;

      if (w_issue) begin
        r_fs_valid <= 1'b1;
        r_fs_pc    <= w_nextpc;
      end else if (w_fs_allowin) begin
        r_fs_valid <= 1'b0;
      end

      // With IF empty, the same-cycle fetch is the delay slot; owe it only if none issues.
      if (w_issue && r_slot_owed)
        r_slot_owed <= 1'b0;
      else if (w_br_live && !r_fs_valid && !w_issue)
        r_slot_owed <= 1'b1;

      if (w_br_live && !(r_fs_valid && w_issue)) begin
        r_br_pend_valid  <= 1'b1;
        r_br_pend_target <= w_br.target;
      end else if (w_issue && !r_slot_owed && r_br_pend_valid) begin
        r_br_pend_valid  <= 1'b0;
      end

      if (r_fs_valid && ds_allowin) begin
        r_inst_buf_valid <= 1'b0;
      end else if (r_issued && r_fs_valid && !r_inst_buf_valid) begin
        r_inst_buf_valid <= 1'b1;
        r_inst_buf       <= inst_sram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: sequential fetch, delayed branches,
// decode backpressure with instruction buffering, stalls, wrap and mid-run reset.
module tb_if_fetch_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        ds_allowin;
  logic [33:0] br_bus;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic [31:0] inst_sram_rdata = 32'h0;
  logic        corrupt = 1'b0;
  int          n_cmp = 0, n_err = 0;

  if_fetch_stage dut (
    .clk(clk), .reset(reset), .ds_allowin(ds_allowin), .br_bus(br_bus),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
    .inst_sram_en(inst_sram_en), .inst_sram_wen(inst_sram_wen),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata)
  );

  always #5 clk = ~clk;

  // SRAM returns ~addr one cycle after an enabled read; corrupt models a changed hold value.
  always @(posedge clk) begin
    if (inst_sram_en)  inst_sram_rdata <= ~inst_sram_addr;
    else if (corrupt)  inst_sram_rdata <= 32'hdeadbeef;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; ds_allowin = 1'b1; br_bus = 34'h0;
    tick(); tick(); settle();
    n_cmp++; if (inst_sram_en !== 1'b0) begin n_err++; $display("FAIL rst_en got %b exp 0", inst_sram_en); end
    n_cmp++; if (fs_to_ds_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b exp 0", fs_to_ds_valid); end
    n_cmp++; if ({inst_sram_wen, inst_sram_wdata} !== 36'h0) begin n_err++; $display("FAIL rst_wr got %h exp 0", {inst_sram_wen, inst_sram_wdata}); end
    n_cmp++; if (fs_to_ds_bus[31:0] !== 32'hbfbffffc) begin n_err++; $display("FAIL rst_pc got %h exp bfbffffc", fs_to_ds_bus[31:0]); end
    reset = 1'b0; settle();
    n_cmp++; if (inst_sram_en !== 1'b1) begin n_err++; $display("FAIL rel_en got %b exp 1", inst_sram_en); end
    n_cmp++; if (inst_sram_addr !== 32'hbfc00000) begin n_err++; $display("FAIL rel_addr got %h exp bfc00000", inst_sram_addr); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pc;
    for (int k = 1; k <= 4; k++) begin
      tick();
      pc = 32'hbfc00000 + 32'(4 * (k - 1));
      n_cmp++; if (inst_sram_addr !== pc + 32'd4 || inst_sram_en !== 1'b1) begin n_err++; $display("FAIL seq_addr[%0d] got %h/%b exp %h/1", k, inst_sram_addr, inst_sram_en, pc + 32'd4); end
      n_cmp++; if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== {~pc, pc}) begin n_err++; $display("FAIL seq_bus[%0d] got %b/%h exp 1/%h", k, fs_to_ds_valid, fs_to_ds_bus, {~pc, pc}); end
    end
  endtask

  task automatic test_branch_valid();
    tick();
    br_bus = {1'b0, 1'b1, 32'hbfc00100}; settle();
    n_cmp++; if (inst_sram_addr !== 32'hbfc00100 || inst_sram_en !== 1'b1) begin n_err++; $display("FAIL br_addr got %h/%b exp bfc00100/1", inst_sram_addr, inst_sram_en); end
    n_cmp++; if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== {~32'hbfc00010, 32'hbfc00010}) begin n_err++; $display("FAIL br_slot got %b/%h exp 1/%h", fs_to_ds_valid, fs_to_ds_bus, {~32'hbfc00010, 32'hbfc00010}); end
    tick(); br_bus = 34'h0; settle();
    n_cmp++; if (fs_to_ds_bus[31:0] !== 32'hbfc00100 || inst_sram_addr !== 32'hbfc00104) begin n_err++; $display("FAIL br_tgt got %h/%h exp bfc00100/bfc00104", fs_to_ds_bus[31:0], inst_sram_addr); end
  endtask

  task automatic test_backpressure();
    ds_allowin = 1'b0; corrupt = 1'b1; settle();
    n_cmp++; if (inst_sram_en !== 1'b0 || inst_sram_addr !== 32'hbfc00104) begin n_err++; $display("FAIL bp0 got %b/%h exp 0/bfc00104", inst_sram_en, inst_sram_addr); end
    for (int k = 1; k <= 2; k++) begin
      tick();
      n_cmp++; if (inst_sram_en !== 1'b0 || fs_to_ds_bus !== {~32'hbfc00100, 32'hbfc00100} || fs_to_ds_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold[%0d] got %b/%h exp 0/%h", k, inst_sram_en, fs_to_ds_bus, {~32'hbfc00100, 32'hbfc00100}); end
    end
    tick(); ds_allowin = 1'b1; corrupt = 1'b0; settle();
    n_cmp++; if (fs_to_ds_bus !== {~32'hbfc00100, 32'hbfc00100} || inst_sram_en !== 1'b1 || inst_sram_addr !== 32'hbfc00104) begin n_err++; $display("FAIL bp_rel got %h/%b/%h exp %h/1/bfc00104", fs_to_ds_bus, inst_sram_en, inst_sram_addr, {~32'hbfc00100, 32'hbfc00100}); end
    tick();
    n_cmp++; if (fs_to_ds_bus !== {~32'hbfc00104, 32'hbfc00104} || fs_to_ds_valid !== 1'b1) begin n_err++; $display("FAIL bp_next got %b/%h exp 1/%h", fs_to_ds_valid, fs_to_ds_bus, {~32'hbfc00104, 32'hbfc00104}); end
  endtask

  task automatic test_br_stall();
    br_bus = {1'b1, 1'b1, 32'hbfc00200};
    for (int k = 0; k < 2; k++) begin
      settle();
      n_cmp++; if (inst_sram_en !== 1'b0 || inst_sram_addr !== 32'hbfc00108) begin n_err++; $display("FAIL stall[%0d] got %b/%h exp 0/bfc00108", k, inst_sram_en, inst_sram_addr); end
      tick();
    end
    br_bus = {1'b0, 1'b1, 32'hbfc00200}; settle();
    n_cmp++; if (fs_to_ds_valid !== 1'b0 || inst_sram_en !== 1'b1 || inst_sram_addr !== 32'hbfc00108) begin n_err++; $display("FAIL stall_drop got %b/%b/%h exp 0/1/bfc00108", fs_to_ds_valid, inst_sram_en, inst_sram_addr); end
    tick(); br_bus = 34'h0; settle();
    n_cmp++; if (inst_sram_addr !== 32'hbfc00200 || inst_sram_en !== 1'b1 || fs_to_ds_bus[31:0] !== 32'hbfc00108) begin n_err++; $display("FAIL stall_tgt got %h/%b/%h exp bfc00200/1/bfc00108", inst_sram_addr, inst_sram_en, fs_to_ds_bus[31:0]); end
    tick();
  endtask

  task automatic test_branch_invalid();
    br_bus = {1'b0, 1'b1, 32'h0000000c}; settle();
    n_cmp++; if (inst_sram_addr !== 32'h0000000c) begin n_err++; $display("FAIL inv_setup got %h exp 0000000c", inst_sram_addr); end
    tick(); br_bus = 34'h0;
    tick();
    br_bus = {1'b1, 1'b0, 32'h0}; tick();
    br_bus = {1'b0, 1'b1, 32'h00000040}; settle();
    n_cmp++; if (fs_to_ds_valid !== 1'b0 || fs_to_ds_bus[31:0] !== 32'h00000010) begin n_err++; $display("FAIL inv_state got %b/%h exp 0/00000010", fs_to_ds_valid, fs_to_ds_bus[31:0]); end
    n_cmp++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h00000014) begin n_err++; $display("FAIL inv_slot got %b/%h exp 1/00000014", inst_sram_en, inst_sram_addr); end
    tick(); br_bus = 34'h0; settle();
    n_cmp++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h00000040 || fs_to_ds_bus[31:0] !== 32'h00000014) begin n_err++; $display("FAIL inv_tgt got %b/%h/%h exp 1/00000040/00000014", inst_sram_en, inst_sram_addr, fs_to_ds_bus[31:0]); end
    tick();
    n_cmp++; if (fs_to_ds_bus !== {~32'h00000040, 32'h00000040} || inst_sram_addr !== 32'h00000044) begin n_err++; $display("FAIL inv_after got %h/%h exp %h/00000044", fs_to_ds_bus, inst_sram_addr, {~32'h00000040, 32'h00000040}); end
  endtask

  task automatic test_wrap();
    br_bus = {1'b0, 1'b1, 32'hfffffffc}; settle();
    tick(); br_bus = 34'h0; settle();
    n_cmp++; if (fs_to_ds_bus[31:0] !== 32'hfffffffc || inst_sram_addr !== 32'h00000000) begin n_err++; $display("FAIL wrap got %h/%h exp fffffffc/00000000", fs_to_ds_bus[31:0], inst_sram_addr); end
    tick();
    n_cmp++; if (fs_to_ds_bus !== {32'hffffffff, 32'h00000000} || inst_sram_addr !== 32'h00000004) begin n_err++; $display("FAIL wrap_next got %h/%h exp ffffffff00000000/00000004", fs_to_ds_bus, inst_sram_addr); end
  endtask

  task automatic test_reset_mid();
    ds_allowin = 1'b0; br_bus = {1'b0, 1'b1, 32'h00000080}; settle();
    tick(); br_bus = 34'h0; corrupt = 1'b1; settle();
    n_cmp++; if (inst_sram_addr !== 32'h00000080 || inst_sram_en !== 1'b0) begin n_err++; $display("FAIL mid_pend got %h/%b exp 00000080/0", inst_sram_addr, inst_sram_en); end
    tick();
    n_cmp++; if (fs_to_ds_bus !== {32'hffffffff, 32'h00000000}) begin n_err++; $display("FAIL mid_buf got %h exp ffffffff00000000", fs_to_ds_bus); end
    reset = 1'b1; corrupt = 1'b0; settle();
    n_cmp++; if (inst_sram_en !== 1'b0) begin n_err++; $display("FAIL mid_rst_en got %b exp 0", inst_sram_en); end
    tick();
    n_cmp++; if (fs_to_ds_valid !== 1'b0 || inst_sram_en !== 1'b0) begin n_err++; $display("FAIL mid_rst got %b/%b exp 0/0", fs_to_ds_valid, inst_sram_en); end
    reset = 1'b0; ds_allowin = 1'b1; settle();
    n_cmp++; if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'hbfc00000) begin n_err++; $display("FAIL mid_rel got %b/%h exp 1/bfc00000", inst_sram_en, inst_sram_addr); end
    tick();
    n_cmp++; if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus !== {~32'hbfc00000, 32'hbfc00000} || inst_sram_addr !== 32'hbfc00004) begin n_err++; $display("FAIL mid_restart got %b/%h/%h exp 1/%h/bfc00004", fs_to_ds_valid, fs_to_ds_bus, inst_sram_addr, {~32'hbfc00000, 32'hbfc00000}); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_branch_valid();
    test_backpressure();
    test_br_stall();
    test_branch_invalid();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'hbfc00000: address of the first instruction fetched after reset.
REQ-002 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ds_allowin  input  1  decode stage can accept an instruction this cycle.
REQ-005 br_bus  input  34  {br_stall[33], br_taken[32], br_target[31:0]} from decode; br_taken is already qualified by decode valid.
REQ-006 fs_to_ds_valid  output  1  fs_to_ds_bus holds a valid instruction.
REQ-007 fs_to_ds_bus  output  64  {fs_inst[63:32], fs_pc[31:0]}.
REQ-008 inst_sram_en  output  1  instruction SRAM read enable.
REQ-009 inst_sram_wen  output  4  byte write enables; constant 4'h0.
REQ-010 inst_sram_addr  output  32  fetch address (nextpc).
REQ-011 inst_sram_wdata  output  32  constant 32'h0.
REQ-012 inst_sram_rdata  input  32  read data, valid the cycle after an enabled read; held by the SRAM while inst_sram_en=0.

Function
REQ-013 Two sub-stages: pre-IF (computes nextpc, issues the SRAM read) and IF (holds fs_valid, fs_pc, instruction).
REQ-014 to_fs_valid = !reset && !br_stall; fs_ready_go = 1; fs_allowin = !fs_valid || (fs_ready_go && ds_allowin); fs_to_ds_valid = fs_valid && fs_ready_go.
REQ-015 inst_sram_en = to_fs_valid && fs_allowin; inst_sram_addr = nextpc every cycle, regardless of enable.
REQ-016 Fetch issue (inst_sram_en=1) loads fs_pc <= nextpc and fs_valid <= 1. Otherwise fs_valid <= 0 when fs_allowin=1. fs_valid holds when fs_allowin=0.
REQ-017 seq_pc = fs_pc + 4, modulo 2^32 (0xfffffffc wraps to 0x00000000).
REQ-018 Delay slot: a taken branch redirects only the fetch after its delay slot. The delay slot is the instruction at branch_pc+4.
REQ-019 Branch sampling: br_taken is honoured only in cycles with br_stall=0. When br_stall=1, no fetch is issued, nextpc holds, and br_taken/br_target are ignored.
REQ-020 Branch seen with fs_valid=1 (delay slot in IF):
- If a fetch issues that cycle, nextpc = br_target.
- Otherwise, set br_pend_valid and latch br_pend_target = br_target.
REQ-021 Branch seen with fs_valid=0 (delay slot not yet fetched):
- Set br_pend_valid, latch br_pend_target, set slot_owed.
- The next issued fetch uses seq_pc (delay slot) and clears slot_owed.
- The following issued fetch uses br_pend_target.
REQ-022 nextpc priority:
1. slot_owed ? seq_pc
2. br_pend_valid ? br_pend_target
3. live taken branch per REQ-020 ? br_target
4. seq_pc
REQ-023 br_pend_valid clears in the cycle the fetch to br_pend_target issues. A new br_taken while br_pend_valid=1 is ignored; decode does not present a second branch before the first redirect completes.
REQ-024 Instruction buffer, set case: in the first cycle after an issue, if fs_valid=1 and ds_allowin=0, set inst_buf_valid and capture inst_buf <= inst_sram_rdata.
REQ-025 Instruction buffer, clear case: inst_buf_valid clears when the IF instruction is accepted (fs_valid && ds_allowin).
REQ-026 fs_inst = inst_buf_valid ? inst_buf : inst_sram_rdata.
REQ-027 No fetch is issued while inst_buf_valid=1 unless the IF instruction leaves that same cycle. fs_allowin already guarantees this.
REQ-028 Latency: fetch issued in cycle N appears on fs_to_ds_bus, with fs_to_ds_valid=1, in cycle N+1.
REQ-029 Simultaneous br_stall=1 and br_taken=1: stall wins; the branch is re-sampled when stall drops.
REQ-030 Simultaneous accept and issue (fs_valid && ds_allowin && to_fs_valid) keeps fs_valid=1 with the new fs_pc. Back-to-back throughput is one instruction per cycle.

Reset
REQ-031 While reset=1: fs_valid=0, fs_pc=RESET_PC-4, br_pend_valid=0, slot_owed=0, inst_buf_valid=0, inst_buf=0.
REQ-032 While reset=1: inst_sram_en=0 and fs_to_ds_valid=0.
REQ-033 First cycle after reset deasserts: inst_sram_en=1, inst_sram_addr=RESET_PC.
REQ-034 Reset asserted mid-operation (pending branch, buffered instruction) discards all state within one cycle. Fetch restarts at RESET_PC.

Verification
REQ-035 Release reset, ds_allowin=1, SRAM returns addr-based data -> addresses 0xbfc00000, 0xbfc00004, 0xbfc00008 on consecutive cycles; fs_to_ds_bus pc lags addr by one cycle.
REQ-036 fs_pc=0xbfc00010 valid, br_taken=1, br_target=0xbfc00100, ds_allowin=1 -> next issued addr 0xbfc00100; the instruction at 0xbfc00010 (delay slot) is still delivered to decode.
REQ-037 ds_allowin=0 for 3 cycles with fs_valid=1, SRAM rdata changed after the first cycle -> fs_inst stays the first-captured word; no fetch issued; on release, the same fs_pc/inst is delivered once and fetch resumes at fs_pc+4.
REQ-038 br_stall=1 for 2 cycles with br_taken=1 -> inst_sram_en=0 and addr unchanged; when stall drops with br_taken=1, target 0xbfc00200 is fetched after the delay slot.
REQ-039 Branch with fs_valid=0 (target 0x00000040, fs_pc=0x00000010) -> issue order 0x00000014 then 0x00000040.
REQ-040 Assert reset while br_pend_valid=1 and inst_buf_valid=1 -> the next cycle has fs_to_ds_valid=0; after release, the first addr is 0xbfc00000.
